// File: rtl/sw_mode_sel_if.sv
// Switch-conditioner bundle: raw switch levels in, debounced levels and
// settled mode code out.
interface sw_mode_sel_if #(
    parameter int N_SW = 10
);
    logic [N_SW-1:0] sw_i;
    logic [N_SW-1:0] sw_db_o;
    logic [3:0]      mode_o;
    logic            mode_valid_o;
    logic            mode_change_o;
    logic            settling_o;

    modport master (
        output sw_i,
        input  sw_db_o, mode_o, mode_valid_o, mode_change_o, settling_o
    );

    modport slave (
        input  sw_i,
        output sw_db_o, mode_o, mode_valid_o, mode_change_o, settling_o
    );
endinterface

// File: rtl/sw_mode_sel.sv
// Synchronise, debounce and priority-encode the board slide switches into a
// registered mode code, with a change strobe and a settle window before valid.
module sw_mode_sel #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int QUIET_CYCLES    = 2500000
) (
    input  logic         clk_50MHz,
    input  logic         rst,
    sw_mode_sel_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int Q_W  = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [Q_W-1:0]  Q_LOAD  = Q_W'((QUIET_CYCLES > 0) ? QUIET_CYCLES - 1 : 0);
    localparam logic [3:0]      MODE_NONE = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN
    } state_t;

    logic [N_SW-1:0] r_sync1;
    logic [N_SW-1:0] r_sync2;
    logic [N_SW-1:0] w_sw_db;
    logic [3:0]      w_cand;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_mode;
    logic [3:0]      w_mode_next;
    logic            r_valid;
    logic            w_valid_next;
    logic            r_change;
    logic            w_change_next;
    logic [Q_W-1:0]  r_qcnt;
    logic [Q_W-1:0]  w_qcnt_next;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.sw_i;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the current debounced level wipes the partial count.
    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_db
            logic [DB_W-1:0] r_cnt;
            logic            r_db;

            always_ff @(posedge clk_50MHz or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_sync2[gi] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_db  <= r_sync2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_sw_db[gi] = r_db;
        end
    endgenerate

    always_comb begin
        w_cand = MODE_NONE;
        for (int i = 0; i < N_SW; i++) begin
            if (w_sw_db[i]) begin
                w_cand = 4'(i);
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_NONE;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
            r_qcnt   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mode   <= w_mode_next;
            r_valid  <= w_valid_next;
            r_change <= w_change_next;
            r_qcnt   <= w_qcnt_next;
        end
    end

    // A new candidate always wins over the settle countdown, from any state.
    always_comb begin
        w_state_next  = r_state;
        w_mode_next   = r_mode;
        w_valid_next  = r_valid;
        w_change_next = 1'b0;
        w_qcnt_next   = r_qcnt;

        if (w_cand != r_mode) begin
            w_mode_next   = w_cand;
            w_change_next = 1'b1;
            w_valid_next  = 1'b0;
            if (w_cand == MODE_NONE) begin
                w_state_next = ST_IDLE;
            end else if (QUIET_CYCLES == 0) begin
                w_state_next = ST_RUN;
                w_valid_next = 1'b1;
            end else begin
                w_state_next = ST_SETTLE;
                w_qcnt_next  = Q_LOAD;
            end
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_qcnt == '0) begin
                        w_state_next = ST_RUN;
                        w_valid_next = 1'b1;
                    end else begin
                        w_qcnt_next = r_qcnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sw_db_o       = w_sw_db;
    assign bus.mode_o        = r_mode;
    assign bus.mode_valid_o  = r_valid;
    assign bus.mode_change_o = r_change;
    assign bus.settling_o    = (r_state == ST_SETTLE);
endmodule

// File: tb/tb_sw_mode_sel.sv
// Randomised bench for sw_mode_sel: a timestamp-based reference model predicts
// every output after each clock edge.
module tb_sw_mode_sel;
    localparam int N_SW = 10;
    localparam int DB   = 4;
    localparam int QC   = 3;

    logic clk;
    logic rst;

    sw_mode_sel_if #(.N_SW(N_SW)) u_if ();

    sw_mode_sel #(
        .N_SW(N_SW),
        .DEBOUNCE_CYCLES(DB),
        .QUIET_CYCLES(QC)
    ) u_dut (
        .clk_50MHz(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: sampled-switch history, debounced levels, and the
    // edge numbers at which each bit last agreed and the mode last changed.
    int          e;
    logic [9:0]  m_h1, m_h2, m_db;
    int          m_last_agree [N_SW];
    logic [3:0]  m_mode;
    logic        m_chg;
    int          m_last_change;

    function automatic logic [3:0] top_code(input logic [9:0] v);
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (v[i]) return 4'(i);
        end
        return 4'hA;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", tag, got, exp, e, $time);
        end
    endtask

    task automatic model_reset();
        m_h1 = '0;
        m_h2 = '0;
        m_db = '0;
        m_mode = 4'hA;
        m_chg = 1'b0;
        m_last_change = e;
        for (int i = 0; i < N_SW; i++) m_last_agree[i] = e;
    endtask

    task automatic model_edge(input logic [9:0] sw);
        logic [3:0] cand;
        logic [9:0] s;
        e++;
        cand = top_code(m_db);
        s = m_h2;
        if (cand != m_mode) begin
            m_mode = cand;
            m_chg = 1'b1;
            m_last_change = e;
        end else begin
            m_chg = 1'b0;
        end
        for (int i = 0; i < N_SW; i++) begin
            if (s[i] == m_db[i]) begin
                m_last_agree[i] = e;
            end else if (e - m_last_agree[i] == DB) begin
                m_db[i] = s[i];
                m_last_agree[i] = e;
            end
        end
        m_h2 = m_h1;
        m_h1 = sw;
    endtask

    task automatic check_all(input string tag);
        logic exp_valid, exp_settle;
        exp_valid  = (m_mode != 4'hA) && ((e - m_last_change) >= QC);
        exp_settle = (m_mode != 4'hA) && ((e - m_last_change) < QC);
        chk({tag, ".db"},     32'(u_if.sw_db_o),      32'(m_db));
        chk({tag, ".mode"},   32'(u_if.mode_o),       32'(m_mode));
        chk({tag, ".valid"},  32'(u_if.mode_valid_o), 32'(exp_valid));
        chk({tag, ".change"}, 32'(u_if.mode_change_o),32'(m_chg));
        chk({tag, ".settle"}, 32'(u_if.settling_o),   32'(exp_settle));
    endtask

    task automatic step(input logic [9:0] sw, input string tag);
        @(negedge clk);
        u_if.sw_i = sw;
        @(posedge clk);
        model_edge(sw);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input logic [9:0] sw, input int n, input string tag);
        $display("phase %s sw=%03h cycles=%0d", tag, sw, n);
        for (int k = 0; k < n; k++) step(sw, tag);
    endtask

    // Reset is raised between edges so the asynchronous clear is observed
    // before any clock edge can act on it.
    task automatic do_reset(input string tag);
        $display("phase %s reset", tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        logic [9:0] rv;
        int         len;
        e = 0;
        rst = 1'b1;
        u_if.sw_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("rst0");

        hold(10'h000, 50, "idle");
        hold(10'h200, 12, "sw9");
        hold(10'h000, 10, "clr");

        hold(10'h008, 2, "b3a");
        hold(10'h000, 2, "b3b");
        hold(10'h008, 12, "b3c");
        hold(10'h000, 10, "clr");

        hold(10'h004, 15, "sw2");
        hold(10'h084, 15, "sw27");
        hold(10'h080, 12, "sw7");
        hold(10'h000, 10, "clr");

        hold(10'h020, 15, "sw5");
        hold(10'h060, 6,  "sw56");
        hold(10'h020, 15, "sw5r");
        hold(10'h000, 10, "clr");

        hold(10'h010, 7, "sw4");
        do_reset("rst1");
        hold(10'h010, 15, "sw4r");

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0: rv = 10'h000;
                1: rv = 10'(1 << $urandom_range(0, 9));
                2: rv = 10'((1 << $urandom_range(0, 9)) | (1 << $urandom_range(0, 9)));
                default: rv = 10'($urandom);
            endcase
            len = $urandom_range(1, 10);
            if ($urandom_range(0, 29) == 0) do_reset("rnd_rst");
            hold(rv, len, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
